// File: rtl/bcd_disp_mux.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Captures packed BCD on load, scans digits from a free-running counter, decodes with optional leading-zero blanking.
module bcd_disp_mux #(
    parameter int unsigned N = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [7:0]  sseg
);

    localparam int unsigned DIGITS = 4;
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned SEG_W  = 8;

    logic [N-1:0]        q_q,    q_d;
    logic [BCD_W-1:0]    bcd_q,  bcd_d;
    logic [DIGITS-1:0]   dp_q,   dp_d;
    logic [DIGITS-1:0]   an_q,   an_d;
    logic [SEG_W-1:0]    sseg_q, sseg_d;

    logic [1:0]          sel;
    logic [3:0]          digit;
    logic [DIGITS-1:0]   lz;

    // Active-low g..a pattern; non-BCD codes render as a dash.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        q_d    = q_q + N'(1);
        bcd_d  = bcd_q;
        dp_d   = dp_q;
        if (load) begin
            bcd_d = bcd_in;
            dp_d  = dp_in;
        end

        sel = q_q[N-1:N-2];
        case (sel)
            2'd0:    digit = bcd_q[3:0];
            2'd1:    digit = bcd_q[7:4];
            2'd2:    digit = bcd_q[11:8];
            default: digit = bcd_q[15:12];
        endcase

        // A digit is a leading zero when it and every more-significant digit are zero.
        lz[3] = (bcd_q[15:12] == 4'd0);
        lz[2] = lz[3] && (bcd_q[11:8] == 4'd0);
        lz[1] = lz[2] && (bcd_q[7:4] == 4'd0);
        lz[0] = 1'b0;

        an_d   = ~(4'b0001 << sel);
        sseg_d = {~dp_q[sel], (blank_lz && lz[sel]) ? 7'b1111111 : seg7(digit)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            bcd_q  <= '0;
            dp_q   <= '0;
            an_q   <= 4'b1111;
            sseg_q <= 8'hFF;
        end else begin
            q_q    <= q_d;
            bcd_q  <= bcd_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
            sseg_q <= sseg_d;
        end
    end

    assign an   = an_q;
    assign sseg = sseg_q;

endmodule

// File: tb/tb_bcd_disp_mux.sv
// Scoreboard bench for bcd_disp_mux: a cycle-level reference model queues the expected display every edge,
// a negedge monitor pops and compares.
module tb_bcd_disp_mux;

    localparam int unsigned N         = 4;
    localparam int          PER_DIGIT = 1 << (N - 2);
    localparam int          FRAME     = 1 << N;

    logic        clk;
    logic        reset;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  an;
    logic [7:0]  sseg;

    bcd_disp_mux #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .bcd_in   (bcd_in),
        .dp_in    (dp_in),
        .load     (load),
        .blank_lz (blank_lz),
        .an       (an),
        .sseg     (sseg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
    };

    int          checks;
    int          passed;
    logic [11:0] exp_q[$];

    // Reference model: elapsed cycles pick the digit, the stored value picks the glyph.
    int          m_cnt;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;
    int          m_dig;
    logic [15:0] m_hi;
    logic [6:0]  m_seg;
    logic [3:0]  m_an;

    always @(posedge clk) begin
        if (reset) begin
            exp_q.push_back({4'b1111, 8'hFF});
            m_cnt = 0;
            m_bcd = '0;
            m_dp  = '0;
        end else begin
            m_dig = (m_cnt / PER_DIGIT) % 4;
            m_hi  = m_bcd >> (4 * m_dig);
            if (blank_lz && m_dig > 0 && m_hi == 16'h0)
                m_seg = 7'h7F;
            else
                m_seg = seg_tab[m_hi[3:0]];
            m_an = ~4'(1 << m_dig);
            exp_q.push_back({m_an, ~m_dp[m_dig], m_seg});
            m_cnt = (m_cnt + 1) % FRAME;
            if (load) begin
                m_bcd = bcd_in;
                m_dp  = dp_in;
            end
        end
    end

    logic [11:0] got;
    logic [11:0] want;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {an, sseg};
            checks++;
            if (got !== want)
                $display("FAIL display t=%0t an=%b sseg=%h required an=%b sseg=%h",
                         $time, got[11:8], got[7:0], want[11:8], want[7:0]);
            else
                passed++;
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d);
        load   = 1'b1;
        bcd_in = b;
        dp_in  = d;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_cnt(input int target, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (m_cnt == target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            $display("FAIL %s wait: counter=%0d required %0d", name, m_cnt, target);
        end
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++)
            v[4*i +: 4] = ($urandom % 3 == 0) ? 4'd0 : 4'($urandom % 16);
        return v;
    endfunction

    initial begin
        bit ok;
        checks   = 0;
        passed   = 0;
        m_cnt    = 0;
        m_bcd    = '0;
        m_dp     = '0;
        reset    = 1'b1;
        load     = 1'b1;
        bcd_in   = 16'h1234;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        run(3);
        reset = 1'b0;
        load  = 1'b0;
        run(FRAME + 2);

        do_load(16'h1234, 4'h0);
        run(2 * FRAME + 4);

        blank_lz = 1'b1;
        do_load(16'h0050, 4'h0);
        run(FRAME + 4);
        do_load(16'h0000, 4'h0);
        run(FRAME + 4);

        do_load(16'h0A09, 4'b0100);
        run(FRAME + 4);

        // Load lands on the same edge the counter wraps.
        blank_lz = 1'b0;
        wait_cnt(FRAME - 1, "rollover", ok);
        if (ok) do_load(16'h9999, 4'h0);
        run(FRAME + 4);

        wait_cnt(9, "midscan", ok);
        if (ok) begin
            reset = 1'b1;
            run(1);
            reset = 1'b0;
        end
        run(FRAME + 4);

        for (int i = 0; i < 1500; i++) begin
            load   = ($urandom % 8 == 0);
            bcd_in = rand_bcd();
            dp_in  = 4'($urandom % 16);
            if ($urandom % 32 == 0) blank_lz = ~blank_lz;
            reset  = ($urandom % 200 == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        load  = 1'b0;
        run(4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
